// File: rtl/multdiv_iter.sv
// multdiv_iter: iterative signed multiply (shift-add) / restoring divide (shift-subtract), one step per clock.
// Build option: define MULTDIV_DIV_EN for the divider; without it ctrl_DIV returns the divide-by-zero response.

module multdiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int            CW        = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      iter_q, iter_d;
  logic               sign_q, sign_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               start, start_div, div_reject;
  logic [2*WIDTH-1:0] acc_step, prod;
  logic               mul_ovf;

  // |INT_MIN| wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
  assign mag_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign mag_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign start     = ctrl_MULT | ctrl_DIV;
  assign start_div = ctrl_DIV & ~ctrl_MULT;

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign prod     = sign_q ? -acc_step : acc_step;
  assign mul_ovf  = ~((&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]));

`ifdef MULTDIV_DIV_EN
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] rem_step, quo_step, quo_signed;
  logic             div_ovf;

  assign shifted    = {rem_q, quo_q[WIDTH-1]};
  // Remainder stays below the divisor, so bit WIDTH of the difference is the borrow.
  assign trial      = shifted - {1'b0, dvsr_q};
  assign rem_step   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_step   = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  assign quo_signed = sign_q ? -quo_step : quo_step;
  assign div_ovf    = quo_step[WIDTH-1] & ~sign_q;
  assign div_reject = start_div & ~(|data_operandB);
`else
  assign div_reject = start_div;
`endif

  always_comb begin
    // NOTE: every next-state variable takes its held value first, so no path can infer a latch.
    state_d  = state_q;
    iter_d   = iter_q;
    sign_d   = sign_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    result_d = result_q;
    exc_d    = exc_q;
`ifdef MULTDIV_DIV_EN
    is_div_d = is_div_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
`endif

    case (state_q)
      S_BUSY: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
`ifdef MULTDIV_DIV_EN
        rem_d    = rem_step;
        quo_d    = quo_step;
`endif
        iter_d   = iter_q + CW'(1);
        if (iter_q == LAST_ITER) begin
          state_d = S_DONE;
`ifdef MULTDIV_DIV_EN
          if (is_div_q) begin
            result_d = quo_signed;
            exc_d    = div_ovf;
          end else begin
            result_d = prod[WIDTH-1:0];
            exc_d    = mul_ovf;
          end
`else
          result_d = prod[WIDTH-1:0];
          exc_d    = mul_ovf;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: ;
    endcase

    // A start in any state aborts whatever is in flight.
    if (start) begin
      if (div_reject) begin
        state_d  = S_DONE;
        result_d = '0;
        exc_d    = 1'b1;
      end else begin
        state_d  = S_BUSY;
        iter_d   = '0;
        sign_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        acc_d    = '0;
        mcand_d  = {{WIDTH{1'b0}}, mag_a};
        mplier_d = mag_b;
`ifdef MULTDIV_DIV_EN
        is_div_d = start_div;
        rem_d    = '0;
        quo_d    = mag_a;
        dvsr_d   = mag_b;
`endif
      end
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q  <= S_IDLE;
      iter_q   <= '0;
      sign_q   <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
`ifdef MULTDIV_DIV_EN
      is_div_q <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      iter_q   <= iter_d;
      sign_q   <= sign_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      exc_q    <= exc_d;
`ifdef MULTDIV_DIV_EN
      is_div_q <= is_div_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
`endif
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == S_DONE);
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_multdiv_iter.sv
// Self-checking bench for multdiv_iter: arithmetic reference model checked every cycle plus directed literal cases.
// Divide expectations follow the MULTDIV_DIV_EN build option.

module tb_multdiv_iter;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        ctrl_mult = 1'b0;
  logic        ctrl_div = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Reference model state.
  bit          m_busy = 1'b0;
  bit          m_rdy = 1'b0;
  bit          m_exc = 1'b0;
  logic [31:0] m_res = '0;
  int          m_left = 0;
  logic [31:0] p_res = '0;
  bit          p_exc = 1'b0;
  bit          p_instant = 1'b0;

  always #5 clock = ~clock;

  multdiv_iter #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (op_a),
    .data_operandB  (op_b),
    .ctrl_MULT      (ctrl_mult),
    .ctrl_DIV       (ctrl_div),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected result from plain signed arithmetic.
  function automatic void model_op(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output bit e, output bit instant);
    longint q;
    instant = 1'b0;
    if (is_mul) begin
      q = longint'($signed(a)) * longint'($signed(b));
      r = q[31:0];
      e = (q > 64'sd2147483647) || (q < -64'sd2147483648);
    end else begin
`ifdef MULTDIV_DIV_EN
      if (b == 32'd0) begin
        r = '0;
        e = 1'b1;
        instant = 1'b1;
      end else begin
        q = longint'($signed(a)) / longint'($signed(b));
        r = q[31:0];
        e = (q > 64'sd2147483647);
      end
`else
      r = '0;
      e = 1'b1;
      instant = 1'b1;
`endif
    end
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_busy = 1'b0;
      m_rdy  = 1'b0;
      m_res  = '0;
      m_exc  = 1'b0;
      m_left = 0;
    end else if (ctrl_mult || ctrl_div) begin
      model_op(ctrl_mult, op_a, op_b, p_res, p_exc, p_instant);
      m_busy = 1'b1;
      if (p_instant) begin
        m_rdy  = 1'b1;
        m_res  = p_res;
        m_exc  = p_exc;
        m_left = 0;
      end else begin
        m_rdy  = 1'b0;
        m_left = 32;
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_rdy = 1'b1;
        m_res = p_res;
        m_exc = p_exc;
      end
    end else if (m_rdy) begin
      m_rdy  = 1'b0;
      m_busy = 1'b0;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("busy", busy, m_busy);
      check("ready", data_resultRDY, m_rdy);
      if (m_rdy) begin
        check("result", data_result, m_res);
        check("exception", data_exception, m_exc);
      end
    end
  end

  task automatic pulse_start(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    @(posedge clock);
    #1;
    ctrl_mult = m;
    ctrl_div  = d;
    op_a      = a;
    op_b      = b;
    @(posedge clock);
    #1;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
  endtask

  // Called just after the start edge; latency counts negedges up to the ready cycle.
  task automatic wait_ready(input string name, input int exp_lat, input logic [31:0] exp_res, input bit exp_exc);
    int lat  = 0;
    bit seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clock);
      lat++;
      seen = data_resultRDY;
    end
    check({name, " ready_seen"}, seen, 1);
    check({name, " latency"}, lat, exp_lat);
    check({name, " result"}, data_result, exp_res);
    check({name, " exception"}, data_exception, exp_exc);
  endtask

  task automatic run_op(input string name, input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input bit exp_exc, input int exp_lat);
    pulse_start(m, d, a, b);
    wait_ready(name, exp_lat, exp_res, exp_exc);
    @(negedge clock);
    check({name, " ready_single"}, data_resultRDY, 0);
    check({name, " busy_low"}, busy, 0);
  endtask

  initial begin
    int pulses;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset busy", busy, 0);
    check("reset ready", data_resultRDY, 0);
    check("reset result", data_result, 0);
    check("reset exception", data_exception, 0);
    @(posedge clock);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    run_op("mul_7_x_m6", 1, 0, 32'd7, -32'sd6, 32'hFFFF_FFD6, 0, 33);
    run_op("mul_ovf", 1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1, 33);
    run_op("mul_to_intmin", 1, 0, -32'sd65536, 32'd32768, 32'h8000_0000, 0, 33);
    run_op("mul_intmin_x_m1", 1, 0, INT_MIN, -32'sd1, 32'h8000_0000, 1, 33);
    run_op("mul_zero", 1, 0, 32'd0, -32'sd12345, 32'h0000_0000, 0, 33);

`ifdef MULTDIV_DIV_EN
    run_op("div_100_m7", 0, 1, 32'd100, -32'sd7, 32'hFFFF_FFF2, 0, 33);
    run_op("div_intmin_m1", 0, 1, INT_MIN, -32'sd1, 32'h8000_0000, 1, 33);
    run_op("div_m7_m2", 0, 1, -32'sd7, -32'sd2, 32'h0000_0003, 0, 33);
    run_op("div_intmin_1", 0, 1, INT_MIN, 32'd1, 32'h8000_0000, 0, 33);
`else
    run_op("div_off_100_m7", 0, 1, 32'd100, -32'sd7, 32'h0000_0000, 1, 1);
    run_op("div_off_intmin_m1", 0, 1, INT_MIN, -32'sd1, 32'h0000_0000, 1, 1);
`endif
    run_op("div_by_zero", 0, 1, 32'd5, 32'd0, 32'h0000_0000, 1, 1);

    // Restart mid-operation: only the second multiply may report.
    pulse_start(1, 0, 32'd3, 32'd4);
    repeat (10) @(posedge clock);
    run_op("restart_9x9", 1, 0, 32'd9, 32'd9, 32'd81, 0, 33);

    run_op("mult_and_div", 1, 1, 32'd6, 32'd3, 32'd18, 0, 33);

    // New start during the DONE cycle.
    pulse_start(1, 0, -32'sd3, 32'd5);
    wait_ready("mul_m3_x_5", 33, 32'hFFFF_FFF1, 0);
    ctrl_mult = 1'b1;
    op_a      = 32'd100000;
    op_b      = 32'd100000;
    @(posedge clock);
    #1;
    ctrl_mult = 1'b0;
    wait_ready("done_restart", 33, 32'h540B_E400, 1);
    @(negedge clock);
    check("done_restart ready_single", data_resultRDY, 0);

    // Reset mid-operation.
    pulse_start(1, 0, 32'd7, -32'sd6);
    repeat (20) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("midreset result", data_result, 0);
    check("midreset exception", data_exception, 0);
    check("midreset ready", data_resultRDY, 0);
    check("midreset busy", busy, 0);
    pulses = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) pulses++;
    end
    check("midreset no_ready_after", pulses, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multdiv_iter.md
# multdiv_iter

Iterative signed 32-bit multiply/divide unit for the processor execute stage. It consumes the operands routed alongside the ALU and shifter, and runs one shift-add (multiply) or shift-subtract (divide) step per clock. It returns the low 32 bits of the product or the truncated quotient with a one-cycle ready pulse. The pipeline stalls on `busy` and writes `data_result` back when `data_resultRDY` fires.

## Interface
- `WIDTH`, 32, operand and result width; the iteration count equals `WIDTH`.
- `clock` input 1 — single clock; all state changes on the rising edge.
- `reset` input 1 — synchronous, active-high.
- `data_operandA` input WIDTH — multiplicand / dividend, two's complement.
- `data_operandB` input WIDTH — multiplier / divisor, two's complement.
- `ctrl_MULT` input 1 — one-cycle start pulse for multiply; operands are sampled on the same edge.
- `ctrl_DIV` input 1 — one-cycle start pulse for divide; operands are sampled on the same edge.
- `data_result` output WIDTH — result; held stable from the ready pulse until the next start.
- `data_exception` output 1 — overflow or divide-by-zero flag; valid with `data_result`.
- `data_resultRDY` output 1 — single-cycle pulse marking the result as valid.
- `busy` output 1 — high while an operation is in flight (states BUSY and DONE).

## Operation
- **States and transitions:**
  - IDLE → BUSY on a start pulse.
  - BUSY → DONE after `WIDTH` iterations.
  - DONE → IDLE on the next edge.
  - IDLE and DONE both accept a new start pulse.
- **Start:**
  - Latch the opcode (MULT/DIV).
  - Latch the operand magnitudes (|x|; |INT_MIN| = 2^31, fits unsigned).
  - Latch the result sign: signA XOR signB.
  - Clear the iteration counter and the accumulators.
- **Simultaneous `ctrl_MULT` and `ctrl_DIV`:** multiply wins; the divide request is dropped.
- **Start while BUSY:** abort the current operation, latch the new operands, restart. No ready pulse is issued for the aborted operation.
- **Multiply:**
  - Per iteration: if multiplier bit 0 = 1, add the multiplicand into the 2·WIDTH-bit product accumulator.
  - Then shift the multiplicand left by 1 and the multiplier right by 1.
  - On completion, negate the 64-bit magnitude if the result sign = 1.
  - `data_result` = low 32 bits.
  - `data_exception` = 1 if the signed product lies outside [−2^31, 2^31−1]. Test: the upper 33 bits are not all equal.
- **Divide (restoring):**
  - Per iteration: shift the {remainder, quotient} register left by 1, with the dividend MSB entering.
  - Trial-subtract the divisor from the remainder. If the result is non-negative, keep it and set quotient bit 0 = 1.
  - On completion, negate the quotient if the result sign = 1 (truncation toward zero). The remainder is discarded.
- **Divide boundaries:**
  - Divisor = 0: skip iteration and go IDLE → DONE directly. `data_result` = 0, `data_exception` = 1.
  - INT_MIN / −1: iterate normally. `data_result` = 32'h8000_0000, `data_exception` = 1.
- **Reset** (any state, including mid-operation) forces IDLE and sets all outputs to 0: `data_result`, `data_exception`, `data_resultRDY`, `busy`. The in-flight operation is discarded and no ready pulse follows.

## Timing
- A start pulse sampled at edge E0 sets BUSY from E0.
- Iterations occur on edges E1..E32; the state is DONE after E32.
- `data_resultRDY` = 1 for exactly one cycle, between E32 and E33. `data_result` and `data_exception` are registered and valid in the same cycle.
- Latency: 33 cycles from the start edge to the end of the ready cycle.
- Divide-by-zero latency: DONE after E0; ready is high between E0 and E1.
- `busy` falls at E33 (or at E1 for divide-by-zero).
- A start pulse in the DONE cycle is accepted: the ready pulse still completes, and the new operation's E0 coincides with the DONE → IDLE edge, which goes to BUSY instead.
- No combinational path from inputs to outputs.

## Configuration
- `MULTDIV_DIV_EN` defined:
  - Full divider datapath, as specified above.
- `MULTDIV_DIV_EN` undefined:
  - Divider datapath and DIV state logic are removed.
  - `ctrl_DIV` is treated like divide-by-zero: DONE one cycle later with `data_result` = 0 and `data_exception` = 1.
  - Multiply is unchanged.

## Test plan
- **Signed multiply:** `ctrl_MULT` with A = 7, B = −6 → exactly 33 cycles later `data_resultRDY` pulses once, `data_result` = 32'hFFFF_FFD6, `data_exception` = 0, `busy` low next cycle.
- **Multiply overflow:** A = 32'h0001_0000, B = 32'h0001_0000 → `data_result` = 0, `data_exception` = 1. Also A = −65536, B = 32768 → `data_result` = 32'h8000_0000, `data_exception` = 0.
- **Signed divide:** A = 100, B = −7 → `data_result` = 32'hFFFF_FFF2 (−14), `data_exception` = 0. Also A = INT_MIN, B = −1 → `data_result` = 32'h8000_0000, `data_exception` = 1.
- **Divide by zero:** A = 5, B = 0 → `data_resultRDY` one cycle after the start, `data_result` = 0, `data_exception` = 1. With `MULTDIV_DIV_EN` undefined, any `ctrl_DIV` gives the same response.
- **Restart mid-operation:** `ctrl_MULT` 3×4, then `ctrl_MULT` 9×9 at iteration 10 → a single ready pulse 33 cycles after the second start, with `data_result` = 81.
- **Reset mid-operation and simultaneous starts:**
  - Reset at iteration 20 → all outputs 0 next cycle and no ready pulse afterwards.
  - `ctrl_MULT` and `ctrl_DIV` together with A = 6, B = 3 → `data_result` = 18.
